secded_enc_engine: RTL and testbench
====================================

# secded_enc_engine

Hardware SECDED (Hamming 16,11) encode engine, the upstream stage of the program-2 decoder. On `start` it reads `NUM_MSG` 11-bit messages from data memory and computes parity bits p8, p4, p2, p1 and overall parity p0. It writes each 16-bit codeword back as two bytes in exactly the layout the decoder consumes. It sits beside the core on the data-memory port and hands off to the decoder through memory plus `done`.

## Interface
- `NUM_MSG`, 15: messages per run.
- `SRC_BASE`, 0: byte address of first message.
- `DST_BASE`, 30: byte address of first codeword.
- `ADDR_W`, 8: memory address width.
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request, sampled high for one cycle.
- `done` out 1: run complete, level.
- `mem_addr` out `ADDR_W`: memory byte address.
- `mem_rd_data` in 8: combinational read data for `mem_addr`, valid in the same cycle.
- `mem_wr_en` out 1: write strobe; the memory captures data on the rising edge.
- `mem_wr_data` out 8: write byte.

## Operation
- **Message i input layout:**
  - low byte at `SRC_BASE+2i` holds d[8:1].
  - high byte at `SRC_BASE+2i+1` holds d[11:9] in bits [2:0].
  - bits [7:3] of the high byte are ignored.
- **Parity equations:**
  - p8 = ^d[11:5]
  - p4 = ^d[11:8] ^ ^d[4:2]
  - p2 = d11^d10^d7^d6^d4^d3^d1
  - p1 = d11^d9^d7^d5^d4^d2^d1
  - p0 = ^d[11:1] ^ p8 ^ p4 ^ p2 ^ p1
- **Codeword:** cw = {d[11:5], p8, d[4:2], p4, d1, p2, p1, p0}.
  - cw[7:0] is written to `DST_BASE+2i`.
  - cw[15:8] is written to `DST_BASE+2i+1`.
- **FSM states:** IDLE, RD_LO, RD_HI, WR_LO, WR_HI, FIN.
  - IDLE: `start` leads to RD_LO, clears `done` and resets index i to 0.
  - RD_LO: latch low byte, go to RD_HI.
  - RD_HI: latch high bits and register cw, go to WR_LO.
  - WR_LO: write cw[7:0], go to WR_HI.
  - WR_HI: write cw[15:8]. If i==NUM_MSG-1, go to FIN; otherwise increment i and go to RD_LO.
  - FIN: set `done`, go to IDLE.
- **Index counter:** width $clog2(NUM_MSG+1). Addresses are computed as base+2i, truncated to `ADDR_W` so they wrap modulo 2^ADDR_W.
- **Outputs:** `mem_wr_en` is high only in WR_LO and WR_HI. `mem_addr` is 0 in IDLE and FIN.

## Timing
- **Reset values:** `done`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, state IDLE, i=0.
- **Throughput:** 4 cycles per message.
- **Latency:** `done` rises 4·NUM_MSG+1 cycles after the edge that sampled `start`. With the defaults this is 61 cycles.
- **`done` hold:** stays high until the next accepted `start`, so `wait(done)` in a bench works.
- **`start` rules:**
  - `start` while busy (not IDLE) is ignored.
  - `start` in the cycle `done` rises is ignored.
  - `start` during IDLE with `done` high begins a new run and clears `done` on the next edge.
- **Reset mid-run:** asserting `reset_n` low asynchronously forces IDLE and drops `mem_wr_en` immediately. Partial writes are left as-is in memory.
- **Overlapping regions:** source and destination regions overlapping is legal. Each message is fully read before its codeword is written.

## Configuration
- **`SECDED_ERR_INJECT_EN` defined:**
  - Adds input ports `inj_en` (1 bit) and `inj_pos` (4 bits).
  - Both are sampled at `start` and held for the whole run.
  - When `inj_en`=1, every written codeword is cw ^ (16'h1 << inj_pos). This produces single-error traffic for the decoder.
- **Macro undefined:** the ports do not exist and codewords are written unmodified.

## Structure
- **Package `secded_pkg`:**
  - state enum `enc_state_t`.
  - bit-position constants P0_POS=0, P1_POS=1, P2_POS=2, P4_POS=4, P8_POS=8.
  - function `secded_encode(logic [11:1] d)` returning logic [15:0]. The decoder reuses it for syndrome generation.
- **Sub-module:** one combinational `hamming_enc16` wrapping `secded_encode`, instantiated once. All sequencing stays in the top FSM.

## Test plan
- Message 11'h000 → bytes 8'h00, 8'h00 at DST_BASE, DST_BASE+1; `done` at cycle 61.
- Message 11'h7FF → cw 16'hFFFF; 11'h001 → 16'h000F; 11'h400 → 16'h8117.
- 15 random messages (high byte bits [7:3] randomised) → every codeword matches the model. Feed the codewords to the program-2 decoder with no flips → each decodes to {5'b00000, d}.
- Pulse `reset_n` low at cycle 20 of a run → `mem_wr_en` drops the same cycle and `done`=0. A fresh `start` then completes all 15 codewords correctly.
- `start` re-pulsed at cycle 10 of a run → ignored, and `done` still rises at cycle 61.
- With `SECDED_ERR_INJECT_EN`, `inj_en`=1, `inj_pos`=5, message 11'h001 → cw 16'h002F.

Source files
------------

// File: rtl/secded_pkg.sv
// Shared SECDED (16,11) definitions: FSM states, parity bit positions and the encode function.
// The program-2 decoder reuses secded_encode for syndrome generation.
package secded_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    FIN   = 3'd5
  } enc_state_t;

  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  // Data bits fill the non-power-of-two positions; p0 is overall parity over cw[15:1].
  function automatic logic [15:0] secded_encode(logic [11:1] d);
    logic        p8;
    logic        p4;
    logic        p2;
    logic        p1;
    logic        p0;
    logic [15:0] cw;
    p8 = ^d[11:5];
    p4 = (^d[11:8]) ^ (^d[4:2]);
    p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
    p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
    p0 = (^d[11:1]) ^ p8 ^ p4 ^ p2 ^ p1;
    cw          = '0;
    cw[15:9]    = d[11:5];
    cw[P8_POS]  = p8;
    cw[7:5]     = d[4:2];
    cw[P4_POS]  = p4;
    cw[3]       = d[1];
    cw[P2_POS]  = p2;
    cw[P1_POS]  = p1;
    cw[P0_POS]  = p0;
    return cw;
  endfunction

endpackage

// File: rtl/hamming_enc16.sv
// Combinational Hamming (16,11) SECDED encoder around secded_pkg::secded_encode.
module hamming_enc16
  import secded_pkg::*;
(
  input  logic [11:1] d_i,
  output logic [15:0] cw_o
);

  assign cw_o = secded_encode(d_i);

endmodule

// File: rtl/secded_enc_engine.sv
// SECDED encode engine: reads NUM_MSG 11-bit messages from memory and writes 16-bit codewords back.
// Optional SECDED_ERR_INJECT_EN adds inj_en/inj_pos to flip one codeword bit per message.
module secded_enc_engine
  import secded_pkg::*;
#(
  parameter int NUM_MSG  = 15,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30,
  parameter int ADDR_W   = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
`ifdef SECDED_ERR_INJECT_EN
  input  logic              inj_en,
  input  logic [3:0]        inj_pos,
`endif
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data
);

  localparam int                IDX_W    = $clog2(NUM_MSG + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MSG - 1);

  enc_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic [7:0]        lowByte_q;
  logic [15:0]       codeword_q;
  logic [15:0]       encCw;
  logic [15:0]       injMask;
  logic [11:1]       encData;
  logic              runAccept;

  logic [ADDR_W-1:0] srcLoAddr, srcHiAddr, dstLoAddr, dstHiAddr;

  assign runAccept = (state_q == IDLE) && start;

  // Addresses wrap modulo 2^ADDR_W by truncation.
  assign srcLoAddr = ADDR_W'(SRC_BASE + 2 * int'(idx_q));
  assign srcHiAddr = ADDR_W'(SRC_BASE + 2 * int'(idx_q) + 1);
  assign dstLoAddr = ADDR_W'(DST_BASE + 2 * int'(idx_q));
  assign dstHiAddr = ADDR_W'(DST_BASE + 2 * int'(idx_q) + 1);

  assign encData = {mem_rd_data[2:0], lowByte_q};

  hamming_enc16 u_hammingEnc (
    .d_i  (encData),
    .cw_o (encCw)
  );

`ifdef SECDED_ERR_INJECT_EN
  logic       injEn_q;
  logic [3:0] injPos_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      injEn_q  <= 1'b0;
      injPos_q <= '0;
    end else if (runAccept) begin
      injEn_q  <= inj_en;
      injPos_q <= inj_pos;
    end
  end

  assign injMask = injEn_q ? (16'h0001 << injPos_q) : 16'h0000;
`else
  assign injMask = 16'h0000;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      done_q     <= 1'b0;
      lowByte_q  <= '0;
      codeword_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (state_q == RD_LO) begin
        lowByte_q <= mem_rd_data;
      end
      if (state_q == RD_HI) begin
        codeword_q <= encCw ^ injMask;
      end
    end
  end

  // Moore outputs: the memory interface depends only on state and index.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = done_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_LO;
          idx_d   = '0;
          done_d  = 1'b0;
        end
      end
      RD_LO: begin
        mem_addr = srcLoAddr;
        state_d  = RD_HI;
      end
      RD_HI: begin
        mem_addr = srcHiAddr;
        state_d  = WR_LO;
      end
      WR_LO: begin
        mem_addr    = dstLoAddr;
        mem_wr_en   = 1'b1;
        mem_wr_data = codeword_q[7:0];
        state_d     = WR_HI;
      end
      WR_HI: begin
        mem_addr    = dstHiAddr;
        mem_wr_en   = 1'b1;
        mem_wr_data = codeword_q[15:8];
        if (idx_q == LAST_IDX) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RD_LO;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_secded_enc_engine.sv
// Self-checking bench for secded_enc_engine: table vectors, random runs against a positional
// Hamming model, start-ignore, mid-run reset and (with SECDED_ERR_INJECT_EN) error injection.
module tb_secded_enc_engine;

  localparam int NUM_MSG  = 15;
  localparam int SRC_BASE = 0;
  localparam int DST_BASE = 30;
  localparam int ADDR_W   = 8;
  localparam int MAX_WAIT = 200;
  localparam int LATENCY  = 4 * NUM_MSG + 1;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              start;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
`ifdef SECDED_ERR_INJECT_EN
  logic              injEn  = 1'b0;
  logic [3:0]        injPos = 4'd0;
`endif

  logic [7:0]  mem [256];
  logic        tbWe   = 1'b0;
  logic [7:0]  tbAddr = '0;
  logic [7:0]  tbData = '0;
  int          wrCount = 0;

  logic [10:0] curMsg  [NUM_MSG];
  logic [4:0]  curJunk [NUM_MSG];
  logic [15:0] curMask = 16'h0000;

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    logic [10:0] msg;
    logic [15:0] expCw;
  } vec_t;
  vec_t vecs [4];

  always #5 clock = ~clock;

  secded_enc_engine #(
    .NUM_MSG  (NUM_MSG),
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
`ifdef SECDED_ERR_INJECT_EN
    .inj_en      (injEn),
    .inj_pos     (injPos),
`endif
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data)
  );

  // Byte-wide memory: combinational read, DUT writes take priority over bench preloads.
  assign mem_rd_data = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wrCount       <= wrCount + 1;
    end else if (tbWe) begin
      mem[tbAddr] <= tbData;
    end
  end

  // Reference: data bits occupy non-power-of-two positions 1..15 in order, each parity at
  // position p covers every position whose index has bit p set, p0 covers cw[15:1].
  function automatic logic [15:0] refEncode(logic [10:0] m);
    logic [15:0] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = m[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if (((pos & p) != 0) && (pos != p)) par = par ^ cw[pos];
      end
      cw[p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  // Decoder model: clean word has zero syndrome and even overall parity; returns FFFF otherwise.
  function automatic logic [15:0] refDecode(logic [15:0] cw);
    int          syn;
    int          k;
    logic [10:0] d;
    syn = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if (cw[pos]) syn = syn ^ pos;
    end
    if ((syn != 0) || ((^cw) != 1'b0)) return 16'hFFFF;
    d = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return {5'b00000, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end else begin
      checksPassed++;
    end
  endtask

  task automatic writeByte(input int addr, input logic [7:0] data);
    @(negedge clock);
    tbWe   = 1'b1;
    tbAddr = addr[7:0];
    tbData = data;
    @(posedge clock);
    #1 tbWe = 1'b0;
  endtask

  // Loads curMsg/curJunk into the source region and poisons the destination region.
  task automatic applyStimulus();
    for (int i = 0; i < NUM_MSG; i++) begin
      writeByte(SRC_BASE + 2 * i, curMsg[i][7:0]);
      writeByte(SRC_BASE + 2 * i + 1, {curJunk[i], curMsg[i][10:8]});
      writeByte(DST_BASE + 2 * i, 8'hAA);
      writeByte(DST_BASE + 2 * i + 1, 8'hAA);
    end
  endtask

  task automatic randomMessages();
    for (int i = 0; i < NUM_MSG; i++) begin
      curMsg[i]  = 11'($urandom);
      curJunk[i] = 5'($urandom);
    end
  endtask

  // Leaves the bench at the negedge right after the edge that sampled start.
  task automatic startRun();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic waitDone(input int pulseAt, output int cycles);
    int n;
    n      = 0;
    cycles = -1;
    while (n < MAX_WAIT) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      start = (n == pulseAt);
      if (done) begin
        cycles = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkRun(input string tag, input bit withDecode);
    logic [15:0] dutCw;
    for (int i = 0; i < NUM_MSG; i++) begin
      dutCw = {mem[DST_BASE + 2 * i + 1], mem[DST_BASE + 2 * i]};
      checkOutput($sformatf("%s_cw%0d", tag, i), 32'(dutCw), 32'(refEncode(curMsg[i]) ^ curMask));
      if (withDecode) begin
        checkOutput($sformatf("%s_decode%0d", tag, i), 32'(refDecode(dutCw)), 32'({5'b00000, curMsg[i]}));
      end
    end
  endtask

  initial begin
    int cycles;
    int wrBefore;
    logic [15:0] partCw;

    vecs[0] = '{msg: 11'h000, expCw: 16'h0000};
    vecs[1] = '{msg: 11'h7FF, expCw: 16'hFFFF};
    vecs[2] = '{msg: 11'h001, expCw: 16'h000F};
    vecs[3] = '{msg: 11'h400, expCw: 16'h8117};

    reset_n = 1'b0;
    start   = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_wr_en", 32'(mem_wr_en), 32'd0);
    checkOutput("reset_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_wr_data", 32'(mem_wr_data), 32'd0);
    reset_n = 1'b1;

    // Run 1: table vectors in slots 0..3, random messages elsewhere.
    randomMessages();
    for (int v = 0; v < 4; v++) curMsg[v] = vecs[v].msg;
    applyStimulus();
    wrBefore = wrCount;
    startRun();
    waitDone(-1, cycles);
    checkOutput("run1_latency", 32'(cycles), 32'(LATENCY));
    checkOutput("run1_write_count", 32'(wrCount - wrBefore), 32'(2 * NUM_MSG));
    checkOutput("run1_zero_lo", 32'(mem[DST_BASE]), 32'h00);
    checkOutput("run1_zero_hi", 32'(mem[DST_BASE + 1]), 32'h00);
    for (int v = 0; v < 4; v++) begin
      checkOutput($sformatf("vec%0d_cw", v),
                  32'({mem[DST_BASE + 2 * v + 1], mem[DST_BASE + 2 * v]}), 32'(vecs[v].expCw));
    end
    checkRun("run1", 1'b1);

    // Run 2: start re-pulsed while busy (sampled at cycle 10) must be ignored.
    randomMessages();
    applyStimulus();
    startRun();
    waitDone(9, cycles);
    checkOutput("run2_latency", 32'(cycles), 32'(LATENCY));
    checkRun("run2", 1'b0);

    // Run 3: start accepted with done high clears done; start in the FIN cycle is ignored.
    randomMessages();
    applyStimulus();
    startRun();
    checkOutput("run3_done_cleared", 32'(done), 32'd0);
    waitDone(60, cycles);
    checkOutput("run3_latency", 32'(cycles), 32'(LATENCY));
    wrBefore = wrCount;
    repeat (8) @(negedge clock);
    checkOutput("run3_done_hold", 32'(done), 32'd1);
    checkOutput("run3_no_extra_writes", 32'(wrCount - wrBefore), 32'd0);
    checkRun("run3", 1'b0);

    // Run 4: asynchronous reset during the high-byte write of message 4.
    randomMessages();
    applyStimulus();
    startRun();
    repeat (19) begin
      @(posedge clock);
      @(negedge clock);
    end
    checkOutput("midreset_wr_en_before", 32'(mem_wr_en), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midreset_wr_en_after", 32'(mem_wr_en), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_addr", 32'(mem_addr), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    partCw = refEncode(curMsg[4]);
    checkOutput("midreset_partial_lo", 32'(mem[DST_BASE + 8]), 32'(partCw[7:0]));
    checkOutput("midreset_partial_hi", 32'(mem[DST_BASE + 9]), 32'hAA);

    // Run 5: fresh start after the reset completes all codewords.
    applyStimulus();
    startRun();
    waitDone(-1, cycles);
    checkOutput("run5_latency", 32'(cycles), 32'(LATENCY));
    checkRun("run5", 1'b1);

`ifdef SECDED_ERR_INJECT_EN
    // Run 6: inj_pos=5 sampled at start; later changes to the inputs must not matter.
    randomMessages();
    curMsg[0] = 11'h001;
    applyStimulus();
    injEn   = 1'b1;
    injPos  = 4'd5;
    curMask = 16'h0020;
    startRun();
    injEn  = 1'b0;
    injPos = 4'd0;
    waitDone(-1, cycles);
    checkOutput("inject_latency", 32'(cycles), 32'(LATENCY));
    checkOutput("inject_cw0", 32'({mem[DST_BASE + 1], mem[DST_BASE]}), 32'h002F);
    checkRun("inject", 1'b0);
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
